pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
//
// PURPOSE
// Program-counter register plus instruction-fetch sequencer, directly downstream of the
// PC4/PCTarget select mux. Captures PCNext when the core retires the current instruction,
// fetches from instruction memory over a req/gnt/rvalid handshake, and holds the fetched
// word with instr_valid until consumed. Supports an asynchronous-to-flow redirect (trap/debug).
//
// PARAMETERS
// RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//
// PORTS
// clk           input   1   system clock, rising edge
// rst_n         input   1   asynchronous active-low reset
// pc_next       input   32  next PC from select mux (PC4 or PCTarget)
// pc_advance    input   1   core consumed instr this cycle; load pc_next
// redirect      input   1   force fetch from redirect_pc; overrides everything except reset
// redirect_pc   input   32  redirect target
// imem_req      output  1   fetch request
// imem_addr     output  32  fetch address (= pc)
// imem_gnt      input   1   request accepted this cycle
// imem_rvalid   input   1   read data valid
// imem_rdata    input   32  read data
// instr_valid   output  1   instr holds a valid word for pc
// instr         output  32  fetched instruction
// pc            output  32  current PC
// pc4           output  32  pc + 4, modulo 2^32
//
// BEHAVIOUR
// - Reset (rst_n=0, async): pc=RESET_PC, state=BOOT, imem_req=0, instr_valid=0, instr=0,
//   discard=0. All outputs registered except imem_addr=pc and pc4=pc+4.
// - States: BOOT -> REQ unconditionally (one cycle, no request).
//   REQ: imem_req=1. gnt=1 -> WAIT next cycle. Address may change while ungranted.
//   WAIT: imem_req=0. rvalid=1 and discard=0 -> instr<=rdata, HOLD next cycle.
//         rvalid=1 and discard=1 -> drop data, clear discard, REQ next cycle.
//   HOLD: instr_valid=1, imem_req=0. pc_advance=1 -> pc<=pc_next, instr_valid<=0, REQ.
// - Best-case fetch: REQ+gnt (cycle 0), rvalid (cycle 1), instr_valid high cycle 2.
// - One outstanding fetch max; rvalid outside WAIT is ignored. gnt outside REQ ignored.
// - pc_advance outside HOLD ignored (no PC change).
// - redirect=1 in any state except BOOT: pc<=redirect_pc, instr_valid<=0.
//   REQ: stay REQ (new address next cycle; gnt same cycle is for old address ->
//        go WAIT with discard=1). WAIT: stay WAIT, discard<=1 unless rvalid same cycle,
//        in which case drop data and go REQ. HOLD: go REQ. BOOT: pc<=redirect_pc, -> REQ.
// - redirect and pc_advance same cycle: redirect wins, pc_next ignored.
// - Alignment: pc[1:0] always 0; pc_next[1:0] and redirect_pc[1:0] discarded.
// - pc4 wraps: pc=32'hFFFF_FFFC -> pc4=32'h0000_0000.
// - Reset mid-fetch: state, pc, discard cleared immediately; a late rvalid in BOOT ignored.
//
// TESTING
// 1 Reset release, RESET_PC=0, gnt tied 1, rvalid one cycle after gnt -> req first high
//   cycle 1, imem_addr=0, instr_valid=1 cycle 3 with instr=rdata.
// 2 HOLD, pc_next=32'h0000_0100, pc_advance=1 -> next cycle pc=0x100, instr_valid=0, req=1.
// 3 WAIT, redirect to 32'h8000_0000, stale rvalid 2 cycles later (rdata 0xDEAD) ->
//   0xDEAD never on instr; next req addr=0x8000_0000.
// 4 HOLD, redirect=1 and pc_advance=1 same cycle, pc_next=0x40, redirect_pc=0x200 -> pc=0x200.
// 5 gnt held low 5 cycles -> req stays high, addr stable, instr_valid low; pc=0xFFFF_FFFC
//   -> pc4=0.
// 6 rst_n low during WAIT then rvalid arrives -> ignored, instr_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter plus a single-outstanding instruction fetch sequencer.
// It fetches the word at pc over req/gnt/rvalid and holds it with instr_valid until the core retires it.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    input  logic        pc_advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        imem_req_q, imem_req_d;
    logic        discard_q, discard_d;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Next-state, next-PC and fetch bookkeeping; redirect overrides normal flow.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        discard_d     = discard_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
                if (redirect) begin
                    pc_d = word_align(redirect_pc);
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    pc_d = word_align(redirect_pc);
                    // A grant in the redirect cycle belongs to the old address.
                    if (imem_gnt) begin
                        state_d   = ST_WAIT;
                        discard_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (imem_gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_d          = word_align(redirect_pc);
                    instr_valid_d = 1'b0;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_rvalid) begin
                    if (discard_q || redirect) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d          = word_align(redirect_pc);
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                end else if (pc_advance) begin
                    pc_d          = word_align(pc_next);
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d       = ST_BOOT;
                instr_valid_d = 1'b0;
                discard_d     = 1'b0;
            end
        endcase
        imem_req_d = (state_d == ST_REQ);
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            discard_q     <= discard_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc4         = pc_q + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot fetch, advance, redirects, stalls, wrap and reset mid-fetch.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_next;
    logic        pc_advance;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;

    int n_checks;
    int n_pass;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_next     (pc_next),
        .pc_advance  (pc_advance),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .pc4         (pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic req, input logic iv, input logic [31:0] exp_pc);
        check_val({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        check_val({tag, "_iv"}, {31'd0, instr_valid}, {31'd0, iv});
        check_val({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        pc_next     = 32'h0000_0000;
        pc_advance  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        repeat (3) tick();

        // Reset state
        check_status("rst", 1'b0, 1'b0, 32'h0000_0000);
        check_val("rst_instr", instr, 32'h0000_0000);
        check_val("rst_pc4", pc4, 32'h0000_0004);

        // Test 1: boot fetch, gnt tied high, rvalid one cycle after gnt
        rst_n    = 1'b1;
        imem_gnt = 1'b1;
        check_val("t1_c0_req", {31'd0, imem_req}, 32'd0);
        tick();
        check_status("t1_c1", 1'b1, 1'b0, 32'h0000_0000);
        check_val("t1_c1_addr", imem_addr, 32'h0000_0000);
        tick();
        check_status("t1_c2", 1'b0, 1'b0, 32'h0000_0000);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_0013;
        tick();
        imem_rvalid = 1'b0;
        check_status("t1_c3", 1'b0, 1'b1, 32'h0000_0000);
        check_val("t1_instr", instr, 32'h1111_0013);

        // Test 2: retire in HOLD loads pc_next
        pc_next    = 32'h0000_0100;
        pc_advance = 1'b1;
        tick();
        pc_advance = 1'b0;
        check_status("t2", 1'b1, 1'b0, 32'h0000_0100);
        check_val("t2_pc4", pc4, 32'h0000_0104);

        // Test 3: redirect in WAIT, stale rvalid two cycles later is dropped
        tick();
        check_status("t3_wait", 1'b0, 1'b0, 32'h0000_0100);
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0000;
        tick();
        redirect = 1'b0;
        check_status("t3_redir", 1'b0, 1'b0, 32'h8000_0000);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_DEAD;
        tick();
        imem_rvalid = 1'b0;
        check_status("t3_drop", 1'b1, 1'b0, 32'h8000_0000);
        check_val("t3_addr", imem_addr, 32'h8000_0000);
        check_val("t3_instr", instr, 32'h1111_0013);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0A13;
        tick();
        imem_rvalid = 1'b0;
        check_status("t3_hold", 1'b0, 1'b1, 32'h8000_0000);
        check_val("t3_instr2", instr, 32'h0000_0A13);

        // Test 4: redirect beats pc_advance; low redirect bits dropped
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0202;
        pc_advance  = 1'b1;
        pc_next     = 32'h0000_0040;
        tick();
        redirect   = 1'b0;
        pc_advance = 1'b0;
        check_status("t4", 1'b1, 1'b0, 32'h0000_0200);

        // Test 5: grant withheld at top of address space, pc4 wraps
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_status("t5_stall", 1'b1, 1'b0, 32'hFFFF_FFFC);
            check_val("t5_addr", imem_addr, 32'hFFFF_FFFC);
            check_val("t5_pc4", pc4, 32'h0000_0000);
            tick();
        end

        // Grant in the redirect cycle is for the old address; its data is dropped
        imem_gnt    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        imem_gnt = 1'b0;
        check_status("gr_wait", 1'b0, 1'b0, 32'h0000_0300);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0BAD;
        tick();
        imem_rvalid = 1'b0;
        check_status("gr_req", 1'b1, 1'b0, 32'h0000_0300);
        check_val("gr_instr", instr, 32'h0000_0A13);

        // Test 6: reset during WAIT, late rvalid ignored
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check_status("t6_wait", 1'b0, 1'b0, 32'h0000_0300);
        rst_n = 1'b0;
        #1;
        check_status("t6_async", 1'b0, 1'b0, 32'h0000_0000);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        tick();
        rst_n = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        check_status("t6_after", 1'b1, 1'b0, 32'h0000_0000);
        check_val("t6_instr", instr, 32'h0000_0000);

        // pc_advance outside HOLD leaves pc alone
        pc_advance = 1'b1;
        pc_next    = 32'h0000_0500;
        tick();
        pc_advance = 1'b0;
        check_status("adv_ign", 1'b1, 1'b0, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
